// File: rtl/fft_shift_pkg.sv
// Shared constants and mapping helpers for the double-buffered IFFT subcarrier mapper.
// The mapping functions take the geometry as arguments so one package serves every instance.
package fft_shift_pkg;

  localparam int N_DEF     = 128;
  localparam int LOG2N_DEF = 7;
  localparam int DW_DEF    = 32;
  localparam int M_DEF     = 62;
  localparam int BIN_W     = 12;

  typedef struct packed {
    logic             we;
    logic [BIN_W-1:0] bin;
  } map_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Reverse all BIN_W bits with fixed indices, then shift down to the LOG2N-bit field.
  function automatic logic [BIN_W-1:0] bitrev(input logic [BIN_W-1:0] j, input int log2n);
    logic [BIN_W-1:0] r;
    for (int i = 0; i < BIN_W; i++) r[i] = j[BIN_W-1-i];
    return r >> (BIN_W - log2n);
  endfunction

  function automatic map_t bin_of_input(input int k, input int n, input int m, input int dc_in);
    map_t r;
    int   half;
    half  = m / 2;
    r.we  = 1'b1;
    r.bin = '0;
    if (k < half)                      r.bin = BIN_W'(n - half + k);
    else if (dc_in != 0 && k == half)  r.we  = 1'b0;
    else                               r.bin = BIN_W'(1 + k - half - dc_in);
    return r;
  endfunction

  function automatic logic is_guard(input int bin, input int n, input int m);
    return (bin == 0) || (bin > m / 2 && bin < n - m / 2);
  endfunction

endpackage

// File: rtl/fft_shift_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks, addressed {bank, bin}.
// The read register only updates on rd_en so a stalled read keeps its data.
module fft_shift_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_shift_pp.sv
// Ping-pong subcarrier mapper: writes used subcarriers into N-bin banks and streams
// each full bank out in natural or bit-reversed order with guard bins forced to zero.
module fft_shift_pp
  import fft_shift_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOG2N  = LOG2N_DEF,
  parameter int DW     = DW_DEF,
  parameter int M      = M_DEF,
  parameter int DC_IN  = 1,
  parameter int BITREV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          frame_err
);

  localparam int L  = M + DC_IN;
  localparam int KW = clog2(L + 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [KW-1:0]    k;
  logic             k_last, s_hs, m_hs;
  map_t             wmap;
  logic             wr_bank, iss_bank, rel_bank;
  logic [1:0]       full, full_set, full_clr;
  logic [LOG2N-1:0] j;
  logic [BIN_W-1:0] rd_bin;
  logic             rd_issue, adv_out;
  logic             p1_valid, p1_guard, p1_last;
  logic [DW-1:0]    rd_data;
  logic             unused_hi;

  // Assert asynchronously, release on a clock edge after two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign s_ready = rst_n && !full[wr_bank];
  assign s_hs    = s_valid && s_ready;
  assign k_last  = (k == KW'(L - 1));
  assign wmap    = bin_of_input(int'(k), N, M, DC_IN);

  assign adv_out  = !m_valid || m_ready;
  assign m_hs     = m_valid && m_ready;
  assign rd_issue = full[iss_bank] && (!p1_valid || adv_out);
  assign rd_bin   = (BITREV != 0) ? bitrev(BIN_W'(j), LOG2N) : BIN_W'(j);

  assign full_set  = (s_hs && k_last) ? (wr_bank  ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr  = (m_hs && m_last) ? (rel_bank ? 2'b10 : 2'b01) : 2'b00;
  assign unused_hi = ^{wmap.bin >> LOG2N, rd_bin >> LOG2N};

  fft_shift_bank_ram #(.AW(LOG2N + 1), .DW(DW)) u_ram (
    .clk     (clk),
    .wr_en   (s_hs && wmap.we),
    .wr_addr ({wr_bank, wmap.bin[LOG2N-1:0]}),
    .wr_data (s_data),
    .rd_en   (rd_issue),
    .rd_addr ({iss_bank, rd_bin[LOG2N-1:0]}),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      wr_bank   <= 1'b0;
      rel_bank  <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= s_hs && (s_last != k_last);
      if (s_hs) begin
        if (k_last) begin
          k       <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          k <= k + 1'b1;
        end
      end
      full <= (full | full_set) & ~full_clr;
      if (m_hs && m_last) rel_bank <= ~rel_bank;
    end
  end

  // Issue side moves to the next bank as soon as the last read is issued, so
  // consecutive frames stream without a gap; release waits for the m_last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j        <= '0;
      iss_bank <= 1'b0;
      p1_valid <= 1'b0;
      p1_guard <= 1'b0;
      p1_last  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      if (rd_issue) begin
        j        <= j + 1'b1;
        p1_valid <= 1'b1;
        p1_guard <= is_guard(int'(rd_bin), N, M);
        p1_last  <= (j == LOG2N'(N - 1));
        if (j == LOG2N'(N - 1)) iss_bank <= ~iss_bank;
      end else if (adv_out) begin
        p1_valid <= 1'b0;
      end
      if (adv_out) begin
        m_valid <= p1_valid;
        m_data  <= (p1_valid && !p1_guard) ? rd_data : '0;
        m_last  <= p1_valid && p1_last;
      end
    end
  end

endmodule

// File: tb/tb_fft_shift_pp.sv
// Scoreboard bench for fft_shift_pp: default geometry plus an N=16 natural-order instance.
module tb_fft_shift_pp;

  localparam int N  = 128;
  localparam int LG = 7;
  localparam int M  = 62;
  localparam int DC = 1;
  localparam int L  = M + DC;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_data = '0, m_data;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready, m_valid, m_ready, m_last, frame_err;
  logic [31:0] b_s_data = '0, b_m_data;
  logic b_s_valid = 1'b0, b_s_last = 1'b0, b_s_ready, b_m_valid, b_m_last, b_frame_err;
  logic b_m_ready = 1'b1;

  fft_shift_pp dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_err(frame_err)
  );

  fft_shift_pp #(.N(16), .LOG2N(4), .DW(32), .M(8), .DC_IN(0), .BITREV(0)) dut_b (
    .clk(clk), .rst(rst), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_last(b_s_last), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_last(b_m_last), .frame_err(b_frame_err)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  exp_t sb[$], sb2[$];
  logic [31:0] out_dat[$];
  int out_cyc[$];
  int out_cnt = 0, last_cnt = 0, err_cnt = 0, b_out_cnt = 0;
  int first_valid_cyc = -1, last_hs_cyc = 0;
  bit rand_bp = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_val(input int n, input int lg, input int m, input int dc,
                                 input int brev, input int j, input int vals[$]);
    int bin;
    bin = j;
    if (brev != 0) begin
      bin = 0;
      for (int i = 0; i < lg; i++) bin = bin | (((j >> i) & 1) << (lg - 1 - i));
    end
    if (bin >= n - m / 2)             return vals[bin - (n - m / 2)];
    if (bin >= 1 && bin <= m / 2)     return vals[m / 2 + dc + bin - 1];
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic prev_stall = 0, prev_valid = 0, prev_last = 0;
  logic [31:0] prev_d = '0;
  bit rise_pend = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 0;
      prev_valid = 0;
      rise_pend  = 0;
    end else begin
      if (rise_pend) begin
        check("s_ready_rise", s_ready, 1);
        rise_pend = 0;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_d);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_err) err_cnt++;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("m_data", m_data, e.d);
          check("m_last", m_last, e.last);
        end
        out_dat.push_back(m_data);
        out_cyc.push_back(cyc);
        out_cnt++;
        if (m_last) last_cnt++;
        if (m_last && !s_ready) rise_pend = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_last  = m_last;
      prev_valid = m_valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && b_m_valid && b_m_ready) begin
      if (sb2.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        e = sb2.pop_front();
        check("b_m_data", b_m_data, e.d);
        check("b_m_last", b_m_last, e.last);
      end
      b_out_cnt++;
    end
  end

  // bad_k < 0: normal framing; otherwise s_last only at k == bad_k.
  task automatic send_frame(input int base, input int bad_k);
    int   vals[$];
    int   t;
    exp_t e;
    for (int k = 0; k < L; k++) vals.push_back(base + k);
    for (int j = 0; j < N; j++) begin
      e.d    = 32'(exp_val(N, LG, M, DC, 1, j, vals));
      e.last = (j == N - 1);
      sb.push_back(e);
    end
    for (int k = 0; k < L; k++) begin
      s_data  = 32'(vals[k]);
      s_valid = 1'b1;
      s_last  = (bad_k < 0) ? (k == L - 1) : (k == bad_k);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) check("s_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      last_hs_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input bit b);
    int t;
    t = 0;
    while ((b ? sb2.size() : sb.size()) > 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(b ? "drain_b" : "drain_a", b ? sb2.size() : sb.size(), 0);
  endtask

  initial begin
    int   base, e0, c0, c1, t;
    int   vals2[$];
    exp_t e;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_b_m_valid", b_m_valid, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("s_ready_after_rst", s_ready, 1);

    // Frame 1: values k+1
    send_frame(1, -1);
    drain(0);
    check("first_valid_latency", first_valid_cyc - last_hs_cyc, 2);
    check("f1_count", out_cnt, N);
    check("f1_last_count", last_cnt, 1);
    check("f1_j67", out_dat[67], 1);
    check("f1_j64", out_dat[64], 33);
    check("f1_j0", out_dat[0], 0);
    check("f1_j1", out_dat[1], 0);
    check("f1_j2", out_dat[2], 0);
    check("f1_no_err", err_cnt, 0);

    // Three frames back-to-back, m_ready high
    base = out_cnt;
    send_frame(100, -1);
    send_frame(300, -1);
    check("both_full_s_ready", s_ready, 0);
    send_frame(500, -1);
    drain(0);
    check("b2b_count", out_cnt - base, 3 * N);
    if (out_cyc.size() >= base + 3 * N)
      check("b2b_no_bubble", out_cyc[base + 3 * N - 1] - out_cyc[base], 3 * N - 1);

    // Same three frames under random backpressure
    rand_bp = 1;
    send_frame(100, -1);
    send_frame(300, -1);
    send_frame(500, -1);
    drain(0);
    rand_bp = 0;

    // Misplaced s_last
    e0 = err_cnt;
    send_frame(700, 10);
    drain(0);
    check("frame_err_pulses", err_cnt - e0, 2);

    // Reset in the middle of a read
    c0 = out_cnt;
    send_frame(900, -1);
    t = 0;
    while (out_cnt - c0 < 40 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("reached_j40", (out_cnt - c0 >= 40) ? 1 : 0, 1);
    #1 rst = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_s_ready", s_ready, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", m_valid, 0);
    check("post_rst_s_ready", s_ready, 1);
    c1 = out_cnt;
    send_frame(2000, -1);
    drain(0);
    check("post_rst_count", out_cnt - c1, N);

    // Small natural-order instance without DC
    for (int k = 0; k < 8; k++) vals2.push_back(k + 1);
    for (int j = 0; j < 16; j++) begin
      e.d    = 32'(exp_val(16, 4, 8, 0, 0, j, vals2));
      e.last = (j == 15);
      sb2.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      b_s_data  = 32'(k + 1);
      b_s_valid = 1'b1;
      b_s_last  = (k == 7);
      t = 0;
      @(negedge clk);
      while (!b_s_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) check("b_s_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
    drain(1);
    check("b_count", b_out_cnt, 16);

    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
